// File: rtl/spi_flash_arb.sv
// Two-port arbiter in front of a single SPI flash command/data interface.
// Round-robin grant, command filtering, and one transaction in flight at a time.
module spi_flash_arb #(
    parameter int unsigned FIRST_PORT = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [7:0]  i_p0_cmd,
    input  logic        i_p0_cmd_valid,
    output logic        o_p0_cmd_ack,
    output logic        o_p0_err,
    input  logic [23:0] i_p0_addr,
    input  logic [8:0]  i_p0_byte_size,
    output logic        o_p0_data_req,
    input  logic [7:0]  i_p0_data_in,
    output logic [7:0]  o_p0_data_out,
    output logic        o_p0_data_valid,

    input  logic [7:0]  i_p1_cmd,
    input  logic        i_p1_cmd_valid,
    output logic        o_p1_cmd_ack,
    output logic        o_p1_err,
    input  logic [23:0] i_p1_addr,
    input  logic [8:0]  i_p1_byte_size,
    output logic        o_p1_data_req,
    input  logic [7:0]  i_p1_data_in,
    output logic [7:0]  o_p1_data_out,
    output logic        o_p1_data_valid,

    output logic [7:0]  o_flash_cmd,
    output logic        o_flash_cmd_valid,
    input  logic        i_flash_cmd_ack,
    output logic [23:0] o_flash_addr,
    output logic [8:0]  o_flash_byte_size,
    input  logic        i_flash_data_req,
    output logic [7:0]  o_flash_data_in,
    input  logic [7:0]  i_flash_data_out,
    input  logic        i_flash_data_valid,

    output logic [1:0]  o_grant,
    output logic        o_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0]  size_q, size_d;
    logic        last_q, last_d;   // 1: port 1 was served last
    logic        err_q, err_d;
    logic        win1;
    logic [7:0]  sel_cmd;

    function automatic logic cmd_ok(input logic [7:0] c);
        return (c == 8'h03) || (c == 8'h02) || (c == 8'hD8) || (c == 8'hC7);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            last_q  <= (FIRST_PORT == 0) ? 1'b1 : 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        size_d  = size_q;
        last_d  = last_q;
        err_d   = err_q;
        win1    = i_p1_cmd_valid & (~i_p0_cmd_valid | ~last_q);
        sel_cmd = win1 ? i_p1_cmd : i_p0_cmd;
        unique case (state_q)
            IDLE: begin
                if (i_p0_cmd_valid || i_p1_cmd_valid) begin
                    grant_d = win1 ? 2'b10 : 2'b01;
                    if (cmd_ok(sel_cmd)) begin
                        cmd_d   = sel_cmd;
                        addr_d  = win1 ? i_p1_addr : i_p0_addr;
                        size_d  = win1 ? i_p1_byte_size : i_p0_byte_size;
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        // Rejected codes never reach the flash registers.
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ISSUE:    state_d = WAIT_ACK;
            WAIT_ACK: if (i_flash_cmd_ack) state_d = DONE;
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                last_d  = grant_q[1];
                err_d   = 1'b0;
            end
            default:  state_d = IDLE;
        endcase
    end

    assign o_flash_cmd       = cmd_q;
    assign o_flash_addr      = addr_q;
    assign o_flash_byte_size = size_q;
    assign o_flash_cmd_valid = (state_q == ISSUE);
    assign o_grant           = grant_q;
    assign o_busy            = (state_q != IDLE);

    assign o_p0_cmd_ack    = (state_q == DONE) & grant_q[0];
    assign o_p1_cmd_ack    = (state_q == DONE) & grant_q[1];
    assign o_p0_err        = o_p0_cmd_ack & err_q;
    assign o_p1_err        = o_p1_cmd_ack & err_q;

    assign o_flash_data_in = grant_q[0] ? i_p0_data_in :
                             grant_q[1] ? i_p1_data_in : '0;
    assign o_p0_data_req   = i_flash_data_req & grant_q[0];
    assign o_p1_data_req   = i_flash_data_req & grant_q[1];
    assign o_p0_data_out   = i_flash_data_out;
    assign o_p1_data_out   = i_flash_data_out;
    assign o_p0_data_valid = i_flash_data_valid & grant_q[0];
    assign o_p1_data_valid = i_flash_data_valid & grant_q[1];

endmodule

// File: tb/tb_spi_flash_arb.sv
// Directed bench for spi_flash_arb: arbitration, command filter, data routing, reset.
module tb_spi_flash_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_p0_cmd, i_p1_cmd;
    logic        i_p0_cmd_valid, i_p1_cmd_valid;
    logic        o_p0_cmd_ack, o_p1_cmd_ack, o_p0_err, o_p1_err;
    logic [23:0] i_p0_addr, i_p1_addr;
    logic [8:0]  i_p0_byte_size, i_p1_byte_size;
    logic        o_p0_data_req, o_p1_data_req;
    logic [7:0]  i_p0_data_in, i_p1_data_in, o_p0_data_out, o_p1_data_out;
    logic        o_p0_data_valid, o_p1_data_valid;
    logic [7:0]  o_flash_cmd;
    logic        o_flash_cmd_valid, i_flash_cmd_ack;
    logic [23:0] o_flash_addr;
    logic [8:0]  o_flash_byte_size;
    logic        i_flash_data_req;
    logic [7:0]  o_flash_data_in, i_flash_data_out;
    logic        i_flash_data_valid;
    logic [1:0]  o_grant;
    logic        o_busy;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_flash_arb #(.FIRST_PORT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_p0_cmd(i_p0_cmd), .i_p0_cmd_valid(i_p0_cmd_valid),
        .o_p0_cmd_ack(o_p0_cmd_ack), .o_p0_err(o_p0_err),
        .i_p0_addr(i_p0_addr), .i_p0_byte_size(i_p0_byte_size),
        .o_p0_data_req(o_p0_data_req), .i_p0_data_in(i_p0_data_in),
        .o_p0_data_out(o_p0_data_out), .o_p0_data_valid(o_p0_data_valid),
        .i_p1_cmd(i_p1_cmd), .i_p1_cmd_valid(i_p1_cmd_valid),
        .o_p1_cmd_ack(o_p1_cmd_ack), .o_p1_err(o_p1_err),
        .i_p1_addr(i_p1_addr), .i_p1_byte_size(i_p1_byte_size),
        .o_p1_data_req(o_p1_data_req), .i_p1_data_in(i_p1_data_in),
        .o_p1_data_out(o_p1_data_out), .o_p1_data_valid(o_p1_data_valid),
        .o_flash_cmd(o_flash_cmd), .o_flash_cmd_valid(o_flash_cmd_valid),
        .i_flash_cmd_ack(i_flash_cmd_ack), .o_flash_addr(o_flash_addr),
        .o_flash_byte_size(o_flash_byte_size), .i_flash_data_req(i_flash_data_req),
        .o_flash_data_in(o_flash_data_in), .i_flash_data_out(i_flash_data_out),
        .i_flash_data_valid(i_flash_data_valid),
        .o_grant(o_grant), .o_busy(o_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_p0_cmd = '0; i_p0_cmd_valid = 1'b0; i_p0_addr = '0; i_p0_byte_size = '0; i_p0_data_in = '0;
        i_p1_cmd = '0; i_p1_cmd_valid = 1'b0; i_p1_addr = '0; i_p1_byte_size = '0; i_p1_data_in = '0;
        i_flash_cmd_ack = 1'b0; i_flash_data_req = 1'b0; i_flash_data_out = '0; i_flash_data_valid = 1'b0;
        repeat (3) tick();
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_flash_cmd", o_flash_cmd, 8'h00);
        chk("rst_cmd_valid", o_flash_cmd_valid, 1'b0);
        chk("rst_p0_ack", o_p0_cmd_ack, 1'b0);
        rst_n = 1'b1;
        tick();

        // p0 READ 0x001000 / 256, address changed while waiting for ack
        i_p0_cmd_valid = 1'b1; i_p0_cmd = 8'h03; i_p0_addr = 24'h001000; i_p0_byte_size = 9'd256;
        tick();
        chk("rd_issue_valid", o_flash_cmd_valid, 1'b1);
        chk("rd_issue_cmd", o_flash_cmd, 8'h03);
        chk("rd_issue_addr", o_flash_addr, 24'h001000);
        chk("rd_issue_size", o_flash_byte_size, 9'd256);
        chk("rd_issue_grant", o_grant, 2'b01);
        chk("rd_issue_busy", o_busy, 1'b1);
        tick();
        chk("rd_wait_valid", o_flash_cmd_valid, 1'b0);
        i_p0_addr = 24'hABCDEF; i_flash_data_req = 1'b1; i_p0_data_in = 8'hA5; i_p1_data_in = 8'h5A;
        i_flash_data_out = 8'h3C; i_flash_data_valid = 1'b1;
        #1;
        chk("rd_addr_hold", o_flash_addr, 24'h001000);
        chk("rd_p0_dreq", o_p0_data_req, 1'b1);
        chk("rd_p1_dreq", o_p1_data_req, 1'b0);
        chk("rd_data_in_mux", o_flash_data_in, 8'hA5);
        chk("rd_p0_dvalid", o_p0_data_valid, 1'b1);
        chk("rd_p1_dvalid", o_p1_data_valid, 1'b0);
        chk("rd_p1_dout", o_p1_data_out, 8'h3C);
        tick();
        chk("rd_addr_hold2", o_flash_addr, 24'h001000);
        chk("rd_no_ack_yet", o_p0_cmd_ack, 1'b0);
        i_flash_data_req = 1'b0; i_flash_data_valid = 1'b0; i_flash_cmd_ack = 1'b1;
        tick();
        chk("rd_done_ack", o_p0_cmd_ack, 1'b1);
        chk("rd_done_err", o_p0_err, 1'b0);
        chk("rd_done_p1ack", o_p1_cmd_ack, 1'b0);
        chk("rd_done_grant", o_grant, 2'b01);
        chk("rd_done_addr", o_flash_addr, 24'h001000);
        i_flash_cmd_ack = 1'b0; i_p0_cmd_valid = 1'b0;
        tick();
        chk("rd_idle_ack", o_p0_cmd_ack, 1'b0);
        chk("rd_idle_grant", o_grant, 2'b00);
        chk("rd_idle_busy", o_busy, 1'b0);
        chk("rd_idle_dmux", o_flash_data_in, 8'h00);

        // Simultaneous requests after reset: p0, then p1 over a repeated p0 request, then p0
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        i_p0_cmd_valid = 1'b1; i_p0_cmd = 8'h03; i_p0_addr = 24'h000010;
        i_p1_cmd_valid = 1'b1; i_p1_cmd = 8'h02; i_p1_addr = 24'h200000; i_p1_byte_size = 9'd1;
        tick();
        chk("rr1_grant", o_grant, 2'b01);
        chk("rr1_cmd", o_flash_cmd, 8'h03);
        tick(); i_flash_cmd_ack = 1'b1; tick();
        chk("rr1_p0_ack", o_p0_cmd_ack, 1'b1);
        chk("rr1_p1_ack", o_p1_cmd_ack, 1'b0);
        i_flash_cmd_ack = 1'b0; i_p0_cmd = 8'hD8; i_p0_addr = 24'h030000;
        tick();
        chk("rr_idle_grant", o_grant, 2'b00);
        tick();
        chk("rr2_grant", o_grant, 2'b10);
        chk("rr2_cmd", o_flash_cmd, 8'h02);
        chk("rr2_addr", o_flash_addr, 24'h200000);
        tick(); i_flash_cmd_ack = 1'b1; tick();
        chk("rr2_p1_ack", o_p1_cmd_ack, 1'b1);
        chk("rr2_p0_ack", o_p0_cmd_ack, 1'b0);
        i_flash_cmd_ack = 1'b0; i_p1_cmd_valid = 1'b0;
        tick(); tick();
        chk("rr3_grant", o_grant, 2'b01);
        chk("rr3_cmd", o_flash_cmd, 8'hD8);
        tick(); i_flash_cmd_ack = 1'b1; tick();
        chk("rr3_p0_ack", o_p0_cmd_ack, 1'b1);
        i_flash_cmd_ack = 1'b0; i_p0_cmd_valid = 1'b0;
        tick();

        // Rejected command on p1
        i_p1_cmd_valid = 1'b1; i_p1_cmd = 8'h9F;
        tick();
        chk("bad_err", o_p1_err, 1'b1);
        chk("bad_ack", o_p1_cmd_ack, 1'b1);
        chk("bad_grant", o_grant, 2'b10);
        chk("bad_no_valid", o_flash_cmd_valid, 1'b0);
        chk("bad_p0_err", o_p0_err, 1'b0);
        i_p1_cmd_valid = 1'b0;
        tick();
        chk("bad_idle_err", o_p1_err, 1'b0);
        chk("bad_idle_valid", o_flash_cmd_valid, 1'b0);
        chk("bad_idle_busy", o_busy, 1'b0);

        // p0 page program with p1 arriving mid-transaction
        i_p0_cmd_valid = 1'b1; i_p0_cmd = 8'h02; i_p0_addr = 24'h000100; i_p0_byte_size = 9'd16;
        tick();
        chk("pp_grant", o_grant, 2'b01);
        i_p1_cmd_valid = 1'b1; i_p1_cmd = 8'hC7;
        tick();
        for (int k = 0; k < 3; k++) begin
            i_flash_data_req = 1'b1; i_flash_data_valid = 1'b1; i_flash_data_out = 8'(8'h10 + k);
            #1;
            chk("pp_p0_dreq", o_p0_data_req, 1'b1);
            chk("pp_p1_dreq", o_p1_data_req, 1'b0);
            chk("pp_p0_dvalid", o_p0_data_valid, 1'b1);
            chk("pp_p1_dvalid", o_p1_data_valid, 1'b0);
            chk("pp_p0_dout", o_p0_data_out, 8'h10 + k);
            tick();
            i_flash_data_req = 1'b0; i_flash_data_valid = 1'b0;
            #1;
            chk("pp_p0_dreq_lo", o_p0_data_req, 1'b0);
            chk("pp_p0_dvalid_lo", o_p0_data_valid, 1'b0);
        end
        i_flash_cmd_ack = 1'b1;
        tick();
        chk("pp_p0_ack", o_p0_cmd_ack, 1'b1);
        chk("pp_p1_ack", o_p1_cmd_ack, 1'b0);
        i_flash_cmd_ack = 1'b0; i_p0_cmd_valid = 1'b0;
        tick(); tick();
        chk("be_grant", o_grant, 2'b10);
        chk("be_cmd", o_flash_cmd, 8'hC7);
        tick(); i_flash_cmd_ack = 1'b1; tick();
        chk("be_p1_ack", o_p1_cmd_ack, 1'b1);
        chk("be_p1_err", o_p1_err, 1'b0);
        i_flash_cmd_ack = 1'b0; i_p1_cmd_valid = 1'b0;
        tick();

        // Reset while waiting for flash ack
        i_p0_cmd_valid = 1'b1; i_p0_cmd = 8'hD8; i_p0_addr = 24'h0F0000; i_p0_byte_size = 9'd5;
        tick(); tick();
        chk("ra_busy", o_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ra_grant", o_grant, 2'b00);
        chk("ra_busy0", o_busy, 1'b0);
        chk("ra_cmd", o_flash_cmd, 8'h00);
        chk("ra_addr", o_flash_addr, 24'h000000);
        chk("ra_size", o_flash_byte_size, 9'd0);
        chk("ra_cmd_valid", o_flash_cmd_valid, 1'b0);
        chk("ra_p0_ack", o_p0_cmd_ack, 1'b0);
        i_flash_cmd_ack = 1'b1; i_p0_cmd_valid = 1'b0;
        tick();
        i_flash_cmd_ack = 1'b0; rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ra_post_ack", o_p0_cmd_ack, 1'b0);
            chk("ra_post_busy", o_busy, 1'b0);
        end
        i_p0_cmd_valid = 1'b1; i_p0_cmd = 8'h03; i_p1_cmd_valid = 1'b1; i_p1_cmd = 8'h03;
        tick();
        chk("ra_first_port", o_grant, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_arb.md
SPI_FLASH_ARB -- requirements
Module: spi_flash_arb

Interface
REQ-001 SHALL have parameter FIRST_PORT, default 0, naming the port that wins the first simultaneous request after reset.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have, for N in {0,1}: i_pN_cmd in 8 (command code); i_pN_cmd_valid in 1 (request level); o_pN_cmd_ack out 1 (completion pulse); o_pN_err out 1 (rejection pulse).
REQ-005 SHALL have, for N in {0,1}: i_pN_addr in 24; i_pN_byte_size in 9; o_pN_data_req out 1; i_pN_data_in in 8; o_pN_data_out out 8; o_pN_data_valid out 1.
REQ-006 SHALL have flash-side ports: o_flash_cmd out 8; o_flash_cmd_valid out 1; i_flash_cmd_ack in 1; o_flash_addr out 24; o_flash_byte_size out 9; i_flash_data_req in 1; o_flash_data_in out 8; i_flash_data_out in 8; i_flash_data_valid in 1.
REQ-007 SHALL have status ports o_grant out 2 (one-hot owner, 00 = none) and o_busy out 1.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT_ACK and DONE.
REQ-009 IDLE: when any i_pN_cmd_valid is high, SHALL select the winner, latch its cmd, addr and byte_size into o_flash_* registers, set o_grant, and go to ISSUE.
REQ-010 Single requester SHALL win; with both requesting, the port not served last SHALL win (round-robin); a last-served pointer updates on every DONE.
REQ-011 Accepted commands SHALL be 8'h03, 8'h02, 8'hD8 and 8'hC7; any other code SHALL skip ISSUE and go IDLE->DONE, pulsing o_pN_err together with o_pN_cmd_ack, with no flash activity.
REQ-012 ISSUE: o_flash_cmd_valid SHALL be high for exactly this one cycle, then the FSM SHALL go to WAIT_ACK.
REQ-013 WAIT_ACK: SHALL hold o_flash_cmd, o_flash_addr and o_flash_byte_size stable, ignore all requests, and go to DONE on i_flash_cmd_ack=1.
REQ-014 DONE: o_pN_cmd_ack of the granted port SHALL be high for exactly this cycle; o_grant SHALL clear on exit; the next state SHALL be IDLE.
REQ-015 Latency: ack in WAIT_ACK at cycle t -> o_pN_cmd_ack at t+1 -> IDLE at t+2, when a new arbitration may occur.
REQ-016 Requester contract: hold valid and fields stable until ack, then deassert valid within 1 cycle; fields changed after grant SHALL have no effect.
REQ-017 o_flash_data_in SHALL be the combinational mux of the granted i_pN_data_in (0 when no grant).
REQ-018 o_pN_data_req SHALL equal i_flash_data_req AND o_grant[N].
REQ-019 o_pN_data_out SHALL equal i_flash_data_out for both ports; o_pN_data_valid SHALL equal i_flash_data_valid AND o_grant[N], including status-poll bytes during PP/SE/BE.
REQ-020 o_busy SHALL be high in every state except IDLE.
REQ-021 The non-granted port's ack, err, data_req and data_valid SHALL stay 0 throughout.
REQ-022 A request arriving on the other port during a transaction SHALL be served at the next IDLE without loss.

Reset
REQ-023 On rst_n low, SHALL go to IDLE and drive all outputs 0 (o_flash_cmd = 8'h00, o_grant = 00, o_busy = 0).
REQ-024 On rst_n low, the last-served pointer SHALL be set so that FIRST_PORT wins first.
REQ-025 Reset mid-transaction SHALL emit no ack or err; requesters re-issue after reset.

Verification
REQ-026 p0 READ at 0x001000, size 256 -> o_flash_cmd=03 and one-cycle valid; flash ack -> o_p0_cmd_ack one cycle later; o_grant 01->00.
REQ-027 p0 and p1 both request in the same cycle after reset (FIRST_PORT=0) -> p0 served then p1; a repeated simultaneous request -> p1 served first.
REQ-028 p1 cmd 8'h9F -> o_p1_err=1 and o_p1_cmd_ack=1 in the same cycle; o_flash_cmd_valid never high.
REQ-029 p0 PP while p1 requests -> p1 sees no data_req or data_valid; all p0 data_req and valid pulses mirrored; p1 served after p0 ack.
REQ-030 rst_n low during WAIT_ACK -> all outputs 0 in the same cycle; no ack after reset is released.
REQ-031 p0 changes i_p0_addr during WAIT_ACK -> o_flash_addr unchanged until DONE.
